// File: rtl/array_mult_seq.sv
// -----------------------------------------------------------------------------
// array_mult_seq
//   Iterative shift-add multiplier: one partial-product row per clock.
//   Sequential successor to the 4x4 combinational array multiplier.
//   Operands are taken over a valid/ready handshake, multiplied either as
//   unsigned or as two's complement (chosen per transaction by in_signed),
//   and the 2*WIDTH-bit product is returned over a valid/ready handshake.
//
// Parameters
//   WIDTH      operand width in bits, 2..32
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present on in_a / in_b / in_signed
//   in_ready   block can accept operands (decoded from state only)
//   in_a       multiplicand
//   in_b       multiplier
//   in_signed  1 = both operands two's complement, 0 = both unsigned
//   out_valid  out_p holds a finished product
//   out_ready  consumer takes the product
//   out_p      product, signed or unsigned per the accepted in_signed
// -----------------------------------------------------------------------------
module array_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $fatal(1, "array_mult_seq: WIDTH must be in 2..32");
        end
    endgenerate

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [WIDTH-1:0]       r_mag_a;
    logic [WIDTH-1:0]       r_mag_b;
    logic                   r_neg;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CW-1:0]          r_cnt;
    logic [2*WIDTH-1:0]     r_p;

    logic                   w_accept;
    logic                   w_last;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic                   w_neg;
    logic [2*WIDTH-1:0]     w_pp;
    logic [2*WIDTH-1:0]     w_acc_sum;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    // The most negative operand negates to 2^(WIDTH-1), which still fits in
    // WIDTH unsigned bits, so magnitudes never need an extra bit.
    always_comb begin
        w_mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        w_mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        w_neg   = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    end

    always_comb begin
        w_pp      = r_mag_b[r_cnt] ? ({{WIDTH{1'b0}}, r_mag_a} << r_cnt) : '0;
        w_acc_sum = r_acc + w_pp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else if (w_accept) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + CW'(1);
            // The final row is folded in here so the product is ready on the
            // same edge that enters DONE; negating zero yields zero.
            if (w_last) begin
                r_p <= r_neg ? -w_acc_sum : w_acc_sum;
            end
        end
    end

    assign out_p = r_p;

endmodule

// File: tb/tb_array_mult_seq.sv
module tb_array_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        iv8, ir8, is8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv4, ir4, is4, ov4, or4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    array_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_signed(is8),
        .out_valid(ov8), .out_ready(or8), .out_p(p8)
    );

    array_mult_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4), .in_signed(is4),
        .out_valid(ov4), .out_ready(or4), .out_p(p4)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] q8[$];
    logic [7:0]  q4[$];

    logic        acc8, fire8, acc4, fire4;
    logic [15:0] cap8;
    logic [7:0]  cap4;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event expected handshake", name);
    endtask

    // One clock: sample handshakes at the falling edge, run the scoreboard,
    // then return 1ns after the rising edge so the caller can drive inputs.
    task automatic tick();
        @(negedge clk);
        acc8  = iv8 && ir8;
        fire8 = ov8 && or8;
        cap8  = p8;
        acc4  = iv4 && ir4;
        fire4 = ov4 && or4;
        cap4  = p4;
        if (acc8) q8.push_back(ref8(a8, b8, is8));
        if (fire8) begin
            if (q8.size() == 0) fail_now("sb8_spurious");
            else chk("sb8_product", 64'(p8), 64'(q8.pop_front()));
        end
        if (acc4) q4.push_back(8'(a4) * 8'(b4));
        if (fire4) begin
            if (q4.size() == 0) fail_now("sb4_spurious");
            else chk("sb4_product", 64'(p4), 64'(q4.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           output logic [15:0] p);
        int n;
        a8 = a; b8 = b; is8 = s; iv8 = 1'b1; or8 = 1'b1;
        n = 0;
        tick();
        while (!acc8 && n < 50) begin tick(); n++; end
        iv8 = 1'b0;
        if (!acc8) fail_now("txn8_accept");
        n = 0;
        tick();
        while (!fire8 && n < 50) begin tick(); n++; end
        if (!fire8) fail_now("txn8_result");
        p = cap8;
    endtask

    task automatic do_txn4(input logic [3:0] a, input logic [3:0] b, output logic [7:0] p);
        int n;
        a4 = a; b4 = b; iv4 = 1'b1; or4 = 1'b1;
        n = 0;
        tick();
        while (!acc4 && n < 50) begin tick(); n++; end
        iv4 = 1'b0;
        if (!acc4) fail_now("txn4_accept");
        n = 0;
        tick();
        while (!fire4 && n < 50) begin tick(); n++; end
        if (!fire4) fail_now("txn4_result");
        p = cap4;
    endtask

    initial begin
        logic [15:0] p;
        logic [7:0]  pq;
        logic [15:0] held;
        int n, issued, received;

        vecs[0] = '{a: 8'h80, b: 8'h80, s: 1'b1, exp: 16'h4000};
        vecs[1] = '{a: 8'hFF, b: 8'h01, s: 1'b1, exp: 16'hFFFF};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, exp: 16'hFE01};
        vecs[3] = '{a: 8'h00, b: 8'h85, s: 1'b1, exp: 16'h0000};
        vecs[4] = '{a: 8'h85, b: 8'h00, s: 1'b1, exp: 16'h0000};
        vecs[5] = '{a: 8'h7F, b: 8'h80, s: 1'b1, exp: 16'hC080};
        vecs[6] = '{a: 8'h03, b: 8'hFD, s: 1'b1, exp: 16'hFFF7};
        vecs[7] = '{a: 8'hFD, b: 8'hFD, s: 1'b1, exp: 16'h0009};
        vecs[8] = '{a: 8'h12, b: 8'h34, s: 1'b0, exp: 16'h03A8};

        rst_n = 1'b0;
        iv8 = 0; is8 = 0; or8 = 0; a8 = 0; b8 = 0;
        iv4 = 0; is4 = 0; or4 = 0; a4 = 0; b4 = 0;
        #12;
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_out_p", 64'(p8), 64'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(ir8), 64'd1);
        chk("rst_in_ready4", 64'(ir4), 64'd1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_txn8(vecs[i].a, vecs[i].b, vecs[i].s, p);
            chk($sformatf("vec%0d", i), 64'(p), 64'(vecs[i].exp));
        end

        // Latency: accept at t0, out_valid low through t0+7, high after t0+8
        a8 = 8'hA5; b8 = 8'h3C; is8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
        n = 0;
        tick();
        while (!acc8 && n < 20) begin tick(); n++; end
        if (!acc8) fail_now("lat_accept");
        a8 = 8'h11; b8 = 8'h22;   // new operands held during CALC and DONE
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lat_valid_c%0d", i), 64'(ov8), 64'd0);
            chk($sformatf("lat_ready_c%0d", i), 64'(ir8), 64'd0);
            tick();
        end
        chk("lat_valid_done", 64'(ov8), 64'd1);
        chk("lat_product", 64'(p8), 64'(16'hA5 * 16'h3C));

        // Backpressure in DONE
        held = p8;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(ov8), 64'd1);
            chk("bp_ready", 64'(ir8), 64'd0);
            chk("bp_stable", 64'(p8), 64'(held));
        end
        or8 = 1'b1;
        tick();
        chk("bp_fire", 64'(fire8), 64'd1);
        chk("bp_idle_ready", 64'(ir8), 64'd1);
        chk("bp_idle_valid", 64'(ov8), 64'd0);
        tick();
        chk("bp_next_accept", 64'(acc8), 64'd1);
        iv8 = 1'b0;
        n = 0;
        tick();
        while (!fire8 && n < 20) begin tick(); n++; end
        if (!fire8) fail_now("bp_next_result");
        chk("bp_next_product", 64'(cap8), 64'(16'h11 * 16'h22));

        // Reset mid-CALC
        a8 = 8'h55; b8 = 8'h66; is8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        n = 0;
        tick();
        while (!acc8 && n < 20) begin tick(); n++; end
        iv8 = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        q8.delete();
        q4.delete();
        #1;
        chk("mid_rst_valid", 64'(ov8), 64'd0);
        chk("mid_rst_out_p", 64'(p8), 64'd0);
        chk("mid_rst_ready", 64'(ir8), 64'd1);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(ir8), 64'd1);
        chk("post_rst_valid", 64'(ov8), 64'd0);
        do_txn8(8'd7, 8'd9, 1'b0, p);
        chk("post_rst_7x9", 64'(p), 64'd63);

        // WIDTH=4 exhaustive unsigned
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_txn4(4'(a), 4'(b), pq);
                chk("w4_exh", 64'(pq), 64'(a * b));
            end
        end

        // Random mix with handshake gaps
        issued = 0; received = 0; n = 0;
        iv8 = 1'b0; or8 = 1'b0;
        while (received < 2000 && n < 80000) begin
            tick();
            n++;
            if (acc8) issued++;
            if (fire8) received++;
            if (!iv8 || acc8) begin
                iv8 = (issued < 2000) && ($urandom_range(3) != 0);
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                is8 = 1'($urandom);
            end
            or8 = ($urandom_range(2) != 0);
        end
        iv8 = 1'b0;
        chk("rand_issued", 64'(issued), 64'd2000);
        chk("rand_received", 64'(received), 64'd2000);
        chk("rand_q_empty", 64'(q8.size()), 64'd0);
        chk("w4_q_empty", 64'(q4.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
